regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the DLX multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;

  function automatic int unsigned addr_w(input int unsigned n);
    return $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = DEF_NREGS,
  localparam int unsigned AW    = addr_w(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_rd,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic             i_flush,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Issue is applied after writeback so a same-cycle newer producer stays outstanding.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_en) begin
      if (i_wr_en) w_busy_nxt[i_wr_addr] = 1'b0;
      if (i_flush) w_busy_nxt = '0;
      else if (i_iss_en) w_busy_nxt[i_iss_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with busy scoreboard and post-reset clear sweep.
// Optional same-cycle write-through bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN  = DEF_XLEN,
  parameter  int unsigned NREGS = DEF_NREGS,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  flush
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_nxt;
  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Sweep walks every register once, then hands over to normal operation.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      CLEAR: begin
        w_ptr_nxt = r_ptr + AW'(1);
        if (r_ptr == AW'(NREGS - 1)) w_state_nxt = RUN;
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign w_run = (r_state == RUN);
  assign ready = w_run;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_run)                    r_mem[r_ptr]   <= '0;
      else if (wr_en && wr_addr != '0) r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_en     (w_run),
    .i_iss_en (iss_en),
    .i_iss_rd (iss_rd),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_flush  (flush),
    .o_busy   (w_busy)
  );

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_byp;
    logic          w_byp_busy;

    assign w_addr = rd_addr[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    assign w_byp      = w_run && wr_en && (wr_addr == w_addr) && (w_addr != '0);
    assign w_byp_busy = iss_en && (iss_rd == w_addr);
`else
    assign w_byp      = 1'b0;
    assign w_byp_busy = 1'b0;
`endif

    assign rd_data[p*XLEN +: XLEN] = (!w_run || w_addr == '0) ? '0 :
                                     w_byp ? wr_data : r_mem[w_addr];
    assign rd_busy[p] = !w_run ? 1'b0 : (w_byp ? w_byp_busy : w_busy[w_addr]);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs a behavioural model.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 2;
  localparam int unsigned AW    = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ready;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic                  flush;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model: cycles since reset release, array contents and busy flags.
  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy = '0;
  int unsigned      m_cnt  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt  = 0;
      m_busy = '0;
    end else if (m_cnt < NREGS) begin
      m_cnt++;
      if (m_cnt == NREGS) for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (flush) m_busy = '0;
      else if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (m_cnt < NREGS || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (m_cnt < NREGS || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return iss_en && iss_rd == a;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), (m_cnt == NREGS) ? 32'd1 : 32'd0);
      for (int p = 0; p < NREAD; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        chk($sformatf("rd_data%0d_r%0d", p, a), rd_data[p*XLEN +: XLEN], exp_data(a));
        chk($sformatf("rd_busy%0d_r%0d", p, a), 32'(rd_busy[p]), 32'(exp_busy(a)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int unsigned a0, input int unsigned a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Waits for ready while hammering write/issue, which must be ignored during the sweep.
  task automatic sweep_wait(input string nm);
    int unsigned n;
    n = 0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = '1; iss_en = 1'b1; iss_rd = 5'd5;
    while (n < 100) begin
      tick();
      n++;
      if (ready) break;
    end
    wr_en = 1'b0; iss_en = 1'b0;
    chk(nm, n, 32'd32);
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 32'(ready), 32'd0);
    tick();
    reset = 1'b0;
    sweep_wait("ready_latency_first");

    // Preload every register with all-ones, then reset and expect a cleared array.
    for (int r = 1; r < NREGS; r++) begin
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = 32'hFFFF_FFFF;
      tick();
    end
    wr_en = 1'b0;
    set_rd(5, 0);
    @(negedge clk);
    chk("preload_r5", rd_data[31:0], 32'hFFFF_FFFF);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_wait("ready_latency_after_reset");
    @(negedge clk);
    chk("r5_cleared", rd_data[31:0], 32'h0);
    chk("r5_not_busy", 32'(rd_busy[0]), 32'd0);

    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    set_rd(0, 7);
    @(negedge clk);
    chk("r7_port1", rd_data[63:32], 32'hDEAD_BEEF);
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0;
    set_rd(0, 0);
    @(negedge clk);
    chk("r0_reads_zero", rd_data[31:0], 32'h0);

    tick();
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    iss_en = 1'b0;
    set_rd(3, 0);
    @(negedge clk);
    chk("r3_busy_after_issue", 32'(rd_busy[0]), 32'd1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("r3_busy_cleared", 32'(rd_busy[0]), 32'd0);
    chk("r3_data", rd_data[31:0], 32'h55);
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h66; iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    @(negedge clk);
    chk("r3_issue_beats_write", 32'(rd_busy[0]), 32'd1);
    chk("r3_data_written", rd_data[31:0], 32'h66);

    // Same-cycle write and read of r9 with a pending producer.
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    iss_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5;
    set_rd(9, 0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("r9_bypass_data", rd_data[31:0], 32'hA5A5_A5A5);
    chk("r9_bypass_busy", 32'(rd_busy[0]), 32'd0);
`else
    chk("r9_old_data", rd_data[31:0], 32'h11);
    chk("r9_old_busy", 32'(rd_busy[0]), 32'd1);
`endif
    tick();
    wr_en = 1'b0;

    for (int r = 2; r <= 6; r += 2) begin
      iss_en = 1'b1; iss_rd = AW'(r);
      tick();
    end
    iss_en = 1'b0;
    set_rd(2, 6);
    @(negedge clk);
    chk("r2_busy_before_flush", 32'(rd_busy[0]), 32'd1);
    chk("r6_busy_before_flush", 32'(rd_busy[1]), 32'd1);
    tick();
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd8;
    tick();
    flush = 1'b0; iss_en = 1'b0;
    set_rd(2, 8);
    @(negedge clk);
    chk("r2_flushed", 32'(rd_busy[0]), 32'd0);
    chk("r8_flush_beats_issue", 32'(rd_busy[1]), 32'd0);
    set_rd(4, 6);
    #1;
    chk("r4_flushed", 32'(rd_busy[0]), 32'd0);
    chk("r6_flushed", 32'(rd_busy[1]), 32'd0);

    // Reset in the middle of a sweep restarts it from register 0.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_wait("ready_latency_midsweep_reset");

    for (int i = 0; i < 2500; i++) begin
      reset   = ($urandom_range(0, 599) == 0);
      rd_addr = NREAD*AW'($urandom);
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      iss_en  = ($urandom_range(0, 2) == 0);
      iss_rd  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      flush   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
      tick();
    end
    reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
